// File: rtl/hazard_ctrl.sv
// Interlock controller for a 5-stage pipeline without forwarding: tracks in-flight
// register writes, stalls dependent ID instructions and squashes wrong-path work on taken branches.
module hazard_ctrl (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        id_valid,
   input  logic [4:0]  id_rs,
   input  logic [4:0]  id_rt,
   input  logic        id_uses_rs,
   input  logic        id_uses_rt,
   input  logic        id_regwr,
   input  logic [4:0]  id_rw,
   input  logic        ex_br_taken,
   output logic        pc_en,
   output logic        id_bubble,
   output logic        if_flush,
   output logic [1:0]  state,
   output logic [15:0] stall_cnt,
   output logic [15:0] flush_cnt
);

   localparam int unsigned REG_W    = 5;
   localparam int unsigned CNT_W    = 16;
   localparam int unsigned SB_DEPTH = 3;

   typedef enum logic [1:0] {
      RUN   = 2'b00,
      STALL = 2'b01,
      FLUSH = 2'b10
   } state_t;

   state_t                          state_q, state_d;
   logic [SB_DEPTH-1:0]             sb_v;
   logic [SB_DEPTH-1:0][REG_W-1:0]  sb_rw;
   logic                            rs_hit, rt_hit;
   logic                            hazard, squash, issue;

   // Compare both sources against every valid in-flight destination (EX, MEM, WR)
   always_comb begin
      rs_hit = 1'b0;
      rt_hit = 1'b0;
      for (int i = 0; i < SB_DEPTH; i++) begin
         if (sb_v[i] && (sb_rw[i] == id_rs)) rs_hit = 1'b1;
         if (sb_v[i] && (sb_rw[i] == id_rt)) rt_hit = 1'b1;
      end
   end

   assign hazard = id_valid &
                   ((id_uses_rs & (id_rs != REG_W'(0)) & rs_hit) |
                    (id_uses_rt & (id_rt != REG_W'(0)) & rt_hit));
   assign squash = ex_br_taken | (state_q == FLUSH);
   assign issue  = id_valid & ~hazard & ~squash;

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= RUN;
      else        state_q <= state_d;
   end

   // Next state and pipeline control; a squash always overrides a stall
   always_comb begin
      state_d   = state_q;
      pc_en     = 1'b1;
      id_bubble = 1'b0;
      if_flush  = 1'b0;

      pc_en     = ~(hazard & ~squash);
      id_bubble = hazard | squash | ~id_valid;
      if_flush  = squash;

      unique case (state_q)
         RUN, STALL, FLUSH: begin
            if (ex_br_taken) state_d = FLUSH;
            else if (hazard) state_d = STALL;
            else             state_d = RUN;
         end
         default: state_d = RUN;
      endcase
   end

   assign state = 2'(state_q);

   // Scoreboard shifts every cycle; register 0 never gets an entry
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sb_v  <= '0;
         sb_rw <= '0;
      end else begin
         sb_v[2]  <= sb_v[1];
         sb_rw[2] <= sb_rw[1];
         sb_v[1]  <= sb_v[0];
         sb_rw[1] <= sb_rw[0];
         if (issue) begin
            sb_v[0]  <= id_regwr & (id_rw != REG_W'(0));
            sb_rw[0] <= id_rw;
         end else begin
            sb_v[0]  <= 1'b0;
            sb_rw[0] <= REG_W'(0);
         end
      end
   end

   // Saturating event counters
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (hazard && !squash && (stall_cnt != {CNT_W{1'b1}}))
            stall_cnt <= stall_cnt + CNT_W'(1);
         if (ex_br_taken && (flush_cnt != {CNT_W{1'b1}}))
            flush_cnt <= flush_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized and directed bench for hazard_ctrl, checked against a cycle-history
// model of in-flight register writes.
module tb_hazard_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        id_valid = 1'b0;
   logic [4:0]  id_rs = '0, id_rt = '0, id_rw = '0;
   logic        id_uses_rs = 1'b0, id_uses_rt = 1'b0, id_regwr = 1'b0;
   logic        ex_br_taken = 1'b0;
   logic        pc_en, id_bubble, if_flush;
   logic [1:0]  state;
   logic [15:0] stall_cnt, flush_cnt;

   int n_tests = 0;
   int n_fail  = 0;

   // Model: destination written by the instruction issued in each cycle
   int cyc     = 0;
   int rst_cyc = 0;
   int dest_hist [int];
   int m_state = 0;
   int m_stall = 0;
   int m_flush = 0;

   hazard_ctrl dut (
      .clk(clk), .rst_n(rst_n),
      .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
      .id_regwr(id_regwr), .id_rw(id_rw), .ex_br_taken(ex_br_taken),
      .pc_en(pc_en), .id_bubble(id_bubble), .if_flush(if_flush),
      .state(state), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
      end
   endtask

   // One clock cycle: drive after negedge, check against the model, advance the model
   task automatic step(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic urs, input logic urt, input logic rgw,
                       input logic [4:0] rw, input logic br, input logic rst);
      bit hz, sq;
      @(negedge clk);
      id_valid = v; id_rs = rs; id_rt = rt; id_uses_rs = urs; id_uses_rt = urt;
      id_regwr = rgw; id_rw = rw; ex_br_taken = br; rst_n = ~rst;
      #1;
      hz = 1'b0;
      if (v) begin
         for (int k = cyc - 1; k >= cyc - 3; k--) begin
            if (k > rst_cyc && dest_hist.exists(k) && dest_hist[k] != 0) begin
               if ((urs && rs != 0 && int'(rs) == dest_hist[k]) ||
                   (urt && rt != 0 && int'(rt) == dest_hist[k])) hz = 1'b1;
            end
         end
      end
      sq = br || (m_state == 2);
      check("pc_en",     32'(pc_en),     32'(!(hz && !sq)));
      check("id_bubble", 32'(id_bubble), 32'(hz || sq || !v));
      check("if_flush",  32'(if_flush),  32'(sq));
      check("state",     32'(state),     32'(m_state));
      check("stall_cnt", 32'(stall_cnt), 32'(m_stall));
      check("flush_cnt", 32'(flush_cnt), 32'(m_flush));
      if (rst) begin
         rst_cyc = cyc;
         m_state = 0;
         m_stall = 0;
         m_flush = 0;
      end else begin
         dest_hist[cyc] = (v && !hz && !sq && rgw) ? int'(rw) : 0;
         m_state = br ? 2 : (hz ? 1 : 0);
         if (hz && !sq && m_stall < 65535) m_stall++;
         if (br && m_flush < 65535) m_flush++;
      end
      if (dest_hist.exists(cyc - 4)) dest_hist.delete(cyc - 4);
      cyc++;
   endtask

   task automatic idle();
      step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
   endtask

   task automatic do_reset();
      step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
   endtask

   initial begin
      int stalls;
      // Reset state and outputs with no instruction
      do_reset();
      idle();
      check("rst_pc_en", 32'(pc_en), 32'd1);
      check("rst_bubble", 32'(id_bubble), 32'd1);
      check("rst_flush", 32'(if_flush), 32'd0);
      check("rst_state", 32'(state), 32'd0);
      check("rst_stall_cnt", 32'(stall_cnt), 32'd0);

      // RAW at distance 1: three stall cycles then issue
      step(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 5'd3, 5'd0, 1'b1, 1'b0, 1'b1, 5'd4, 1'b0, 1'b0);
         check("raw1_pc_en", 32'(pc_en), 32'd0);
         check("raw1_bubble", 32'(id_bubble), 32'd1);
      end
      step(1'b1, 5'd3, 5'd0, 1'b1, 1'b0, 1'b1, 5'd4, 1'b0, 1'b0);
      check("raw1_issue", 32'(pc_en), 32'd1);
      check("raw1_state", 32'(state), 32'd1);
      check("raw1_stall_cnt", 32'(stall_cnt), 32'd3);

      // Stall length versus producer distance
      for (int d = 1; d <= 5; d++) begin
         repeat (4) idle();
         step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0);
         repeat (d - 1) idle();
         stalls = 0;
         step(1'b1, 5'd9, 5'd7, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
         while (!pc_en && stalls < 10) begin
            stalls++;
            step(1'b1, 5'd9, 5'd7, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
         end
         check($sformatf("dist%0d_stalls", d), 32'(stalls), 32'((d < 4) ? 4 - d : 0));
      end

      // Register 0 never interlocks
      do_reset();
      step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0);
      step(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0);
      check("r0_pc_en", 32'(pc_en), 32'd1);
      idle();
      check("r0_stall_cnt", 32'(stall_cnt), 32'd0);

      // Taken branch: two squash cycles, then back to RUN
      do_reset();
      step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd6, 1'b1, 1'b0);
      check("br_flush0", 32'(if_flush), 32'd1);
      step(1'b1, 5'd6, 5'd0, 1'b1, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0);
      check("br_state1", 32'(state), 32'd2);
      check("br_flush1", 32'(if_flush), 32'd1);
      check("br_flush_cnt", 32'(flush_cnt), 32'd1);
      step(1'b1, 5'd6, 5'd8, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
      check("br_state2", 32'(state), 32'd0);
      check("br_no_wrongpath_entry", 32'(pc_en), 32'd1);

      // Branch arriving while a consumer is stalled
      do_reset();
      step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd4, 1'b0, 1'b0);
      step(1'b1, 5'd4, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
      check("brst_stall", 32'(pc_en), 32'd0);
      step(1'b1, 5'd4, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
      check("brst_pc_en", 32'(pc_en), 32'd1);
      check("brst_flush", 32'(if_flush), 32'd1);
      idle();
      check("brst_state", 32'(state), 32'd2);
      check("brst_stall_cnt", 32'(stall_cnt), 32'd1);

      // Reset in the middle of a stall with a full scoreboard
      do_reset();
      step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd1, 1'b0, 1'b0);
      step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd2, 1'b0, 1'b0);
      step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd3, 1'b0, 1'b0);
      step(1'b1, 5'd1, 5'd3, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
      check("mid_rst_stalled", 32'(pc_en), 32'd0);
      step(1'b1, 5'd1, 5'd3, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1);
      step(1'b1, 5'd1, 5'd3, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
      check("mid_rst_issue", 32'(pc_en), 32'd1);
      check("mid_rst_state", 32'(state), 32'd0);
      check("mid_rst_stall_cnt", 32'(stall_cnt), 32'd0);

      // Randomized traffic over a small register range to force frequent matches
      for (int i = 0; i < 1500; i++) begin
         step(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
              1'($urandom), 1'($urandom), 1'($urandom), 5'($urandom_range(0, 7)),
              1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 99) == 0));
      end

      // Stall counter saturation under a self-dependent instruction stream
      do_reset();
      for (int i = 0; i < 95000; i++) begin
         if (m_stall == 65535 && stall_cnt == 16'hFFFF && i > 0) break;
         step(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0);
      end
      repeat (8) step(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0);
      check("sat_stall_cnt", 32'(stall_cnt), 32'hFFFF);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
